// File: rtl/tetris_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tetris_pkg                                                 |
// | Brief    : Shared command codes, FSM states and priority helpers for  |
// |            the move scheduler.                                        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LEFT  = 3'd1,
        CMD_RIGHT = 3'd2,
        CMD_DOWN  = 3'd3,
        CMD_SPIN  = 3'd4,
        CMD_GRAV  = 3'd5
    } move_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        LOCK  = 2'd2
    } sched_state_t;

    localparam int unsigned NUM_KEYS = 4;

    // Bit positions inside the pending vector
    localparam int unsigned PB_LEFT  = 0;
    localparam int unsigned PB_RIGHT = 1;
    localparam int unsigned PB_DOWN  = 2;
    localparam int unsigned PB_SPIN  = 3;
    localparam int unsigned PB_GRAV  = 4;

    // Highest-priority pending command: GRAV > SPIN > LEFT > RIGHT > DOWN
    function automatic move_cmd_t pick_cmd(input logic [4:0] p);
        move_cmd_t c;
        c = CMD_NONE;
        if      (p[PB_GRAV])  c = CMD_GRAV;
        else if (p[PB_SPIN])  c = CMD_SPIN;
        else if (p[PB_LEFT])  c = CMD_LEFT;
        else if (p[PB_RIGHT]) c = CMD_RIGHT;
        else if (p[PB_DOWN])  c = CMD_DOWN;
        return c;
    endfunction

    // Pending-vector bit owned by a command
    function automatic logic [4:0] cmd_mask(input move_cmd_t c);
        logic [4:0] m;
        m = 5'b0;
        case (c)
            CMD_LEFT:  m[PB_LEFT]  = 1'b1;
            CMD_RIGHT: m[PB_RIGHT] = 1'b1;
            CMD_DOWN:  m[PB_DOWN]  = 1'b1;
            CMD_SPIN:  m[PB_SPIN]  = 1'b1;
            CMD_GRAV:  m[PB_GRAV]  = 1'b1;
            default:   m = 5'b0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : move_scheduler_if                                          |
// | Brief    : Command offer/acknowledge handshake between the scheduler  |
// |            (master) and the game engine (slave).                      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface move_scheduler_if;
    import tetris_pkg::*;

    logic      moveValid;
    move_cmd_t moveCmd;
    logic      moveAck;
    logic      moveBlocked;

    modport master (output moveValid, output moveCmd, input moveAck, input moveBlocked);
    modport slave  (input moveValid, input moveCmd, output moveAck, output moveBlocked);

endinterface
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : key_repeat                                                 |
// | Brief    : Rising-edge detector plus auto-repeat timer for one key.   |
// |            fire pulses on the press cycle, REPEAT_DELAY cycles later, |
// |            then every REPEAT_PERIOD cycles while the key stays high.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module key_repeat #(
    parameter int REPEAT_DELAY  = 24,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    input  logic clear,
    output logic fire
);

    localparam logic [7:0] DELAY_LD  = 8'(REPEAT_DELAY);
    localparam logic [7:0] PERIOD_LD = 8'(REPEAT_PERIOD);

    logic       key_prev;
    logic [7:0] cnt;
    logic       rise;
    logic       held;

    assign rise = key_in & ~key_prev;
    assign held = key_in & key_prev;
    // A count of 1 marks the cycle a repeat is due; 0 means the timer is idle
    assign fire = ~clear & (rise | (held & (cnt == 8'd1)));

    // Previous level and repeat countdown; clear leaves held keys needing a new edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev <= 1'b0;
            cnt      <= 8'd0;
        end else begin
            key_prev <= key_in;
            if (clear || !key_in) begin
                cnt <= 8'd0;
            end else if (rise) begin
                cnt <= DELAY_LD;
            end else if (cnt == 8'd1) begin
                cnt <= PERIOD_LD;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/move_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : move_scheduler                                             |
// | Brief    : Collects key presses, auto-repeats and gravity ticks into  |
// |            pending bits and offers them one at a time to the engine.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int REPEAT_DELAY  = 24,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    leftIn,
    input  logic                    rightIn,
    input  logic                    downIn,
    input  logic                    spinIn,
    input  logic                    dropTick,
    move_scheduler_if.master        eng,
    output logic                    lockOut,
    output logic                    busy
);

    sched_state_t         state;
    sched_state_t         next_state;
    move_cmd_t            cmd_q;
    move_cmd_t            next_cmd;
    logic [4:0]           pend;
    logic [4:0]           next_pend;
    logic [4:0]           set_vec;
    logic [4:0]           eff_pend;
    logic [NUM_KEYS-1:0]  keys;
    logic [NUM_KEYS-1:0]  key_fire;
    logic                 in_lock;

    assign keys    = {spinIn, downIn, rightIn, leftIn};
    assign in_lock = (state == LOCK);

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_keys
            key_repeat #(
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_key (
                .clk    (clk),
                .reset  (reset),
                .key_in (keys[k]),
                .clear  (in_lock),
                .fire   (key_fire[k])
            );
        end
    endgenerate

    // Key order in keys[] matches PB_LEFT..PB_SPIN, gravity on top
    assign set_vec  = {dropTick, key_fire};
    // Events arriving this cycle are already eligible for selection
    assign eff_pend = pend | set_vec;

    // Next state, latched command and pending bits; a new set beats an ack clear
    always_comb begin
        next_state = state;
        next_cmd   = cmd_q;
        next_pend  = pend | set_vec;
        case (state)
            IDLE: begin
                if (|eff_pend) begin
                    next_cmd   = pick_cmd(eff_pend);
                    next_state = OFFER;
                end
            end
            OFFER: begin
                if (eng.moveAck) begin
                    next_pend = set_vec | (pend & ~cmd_mask(cmd_q));
                    if (cmd_q == CMD_GRAV && eng.moveBlocked) begin
                        next_state = LOCK;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            LOCK: begin
                // Only a tick arriving in the lock cycle itself survives
                next_pend  = {dropTick, 4'b0000};
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, command and pending registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cmd_q <= CMD_NONE;
            pend  <= 5'b0;
        end else begin
            state <= next_state;
            cmd_q <= next_cmd;
            pend  <= next_pend;
        end
    end

    // Outputs decode from state only, so reset clears them without a clock edge
    assign eng.moveValid = (state == OFFER);
    assign eng.moveCmd   = (state == OFFER) ? cmd_q : CMD_NONE;
    assign lockOut       = (state == LOCK);
    assign busy          = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_move_scheduler                                          |
// | Brief    : Table-driven directed cases, async-reset sequences and a   |
// |            randomized run against a timing-rule reference model.      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_move_scheduler;
    import tetris_pkg::*;

    localparam int RD = 4;
    localparam int RP = 2;

    logic clk = 1'b0;
    logic reset;
    logic k_left, k_right, k_down, k_spin, drop;
    logic lock_out, busy;
    int   n_cmp = 0;
    int   n_bad = 0;

    move_scheduler_if eng();

    move_scheduler #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk      (clk),
        .reset    (reset),
        .leftIn   (k_left),
        .rightIn  (k_right),
        .downIn   (k_down),
        .spinIn   (k_spin),
        .dropTick (drop),
        .eng      (eng),
        .lockOut  (lock_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        l, r, d, s, g, ack, blk;
        int        reps;
        bit        ev;
        move_cmd_t ec;
        bit        el;
    } vec_t;

    vec_t vec[29];

    // Reference model state: per-key press time, pending flags by code, offer/lock
    int m_since[4];
    bit m_prev[4];
    bit m_pend[1:5];
    int m_offer;
    bit m_lock;
    int m_t;
    int prio[5] = '{5, 4, 1, 2, 3};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input bit ev, input move_cmd_t ec, input bit el);
        chk({tag, ".valid"}, int'(eng.moveValid), int'(ev));
        chk({tag, ".cmd"},   int'(eng.moveCmd),   int'(ec));
        chk({tag, ".lock"},  int'(lock_out),      int'(el));
        chk({tag, ".busy"},  int'(busy),          int'(ev | el));
    endtask

    task automatic drive(input bit l, r, d, s, g, ack, blk);
        k_left = l; k_right = r; k_down = d; k_spin = s; drop = g;
        eng.moveAck = ack; eng.moveBlocked = blk;
    endtask

    // One clock: outputs checked mid-cycle, then advance past the edge
    task automatic tick_chk(input string tag, input bit ev, input move_cmd_t ec, input bit el);
        @(negedge clk);
        expect_out(tag, ev, ec, el);
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin m_since[k] = -1; m_prev[k] = 1'b0; end
        for (int c = 1; c <= 5; c++) m_pend[c] = 1'b0;
        m_offer = 0; m_lock = 1'b0; m_t = 0;
    endtask

    task automatic model_step();
        bit kin[4];
        bit fire[1:5];
        int d;
        kin = '{k_left, k_right, k_down, k_spin};
        for (int c = 1; c <= 5; c++) fire[c] = 1'b0;
        fire[5] = drop;
        if (m_lock) begin
            for (int c = 1; c <= 5; c++) m_pend[c] = 1'b0;
            m_pend[5] = drop;
            for (int k = 0; k < 4; k++) begin m_since[k] = -1; m_prev[k] = kin[k]; end
            m_lock = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (kin[k] && !m_prev[k]) begin
                    fire[k+1] = 1'b1;
                    m_since[k] = m_t;
                end else if (kin[k] && m_since[k] >= 0) begin
                    d = m_t - m_since[k];
                    if (d >= RD && ((d - RD) % RP) == 0) fire[k+1] = 1'b1;
                end else if (!kin[k]) begin
                    m_since[k] = -1;
                end
                m_prev[k] = kin[k];
            end
            if (m_offer != 0) begin
                if (eng.moveAck) begin
                    m_pend[m_offer] = 1'b0;
                    if (m_offer == 5 && eng.moveBlocked) m_lock = 1'b1;
                    m_offer = 0;
                end
                for (int c = 1; c <= 5; c++) m_pend[c] |= fire[c];
            end else begin
                for (int c = 1; c <= 5; c++) m_pend[c] |= fire[c];
                for (int p = 0; p < 5; p++)
                    if (m_offer == 0 && m_pend[prio[p]]) m_offer = prio[p];
            end
        end
        m_t++;
    endtask

    initial begin
        //           l r d s g ack blk reps ev  ec         el
        vec[0]  = '{1,0,0,0,0, 1, 0,  1,  0, CMD_NONE,  0};  // press
        vec[1]  = '{1,0,0,0,0, 1, 0,  1,  1, CMD_LEFT,  0};  // press+1
        vec[2]  = '{1,0,0,0,0, 1, 0,  3,  0, CMD_NONE,  0};
        vec[3]  = '{1,0,0,0,0, 1, 0,  1,  1, CMD_LEFT,  0};  // press+5
        vec[4]  = '{1,0,0,0,0, 1, 0,  1,  0, CMD_NONE,  0};
        vec[5]  = '{1,0,0,0,0, 1, 0,  1,  1, CMD_LEFT,  0};  // press+7
        vec[6]  = '{1,0,0,0,0, 1, 0,  1,  0, CMD_NONE,  0};
        vec[7]  = '{1,0,0,0,0, 1, 0,  1,  1, CMD_LEFT,  0};  // press+9
        vec[8]  = '{0,0,0,0,0, 1, 0,  3,  0, CMD_NONE,  0};  // released
        vec[9]  = '{0,0,0,1,1, 0, 0,  1,  0, CMD_NONE,  0};  // tick + spin together
        vec[10] = '{0,0,0,0,0, 1, 0,  1,  1, CMD_GRAV,  0};
        vec[11] = '{0,0,0,0,0, 1, 0,  1,  0, CMD_NONE,  0};
        vec[12] = '{0,0,0,0,0, 1, 0,  1,  1, CMD_SPIN,  0};
        vec[13] = '{0,0,0,0,0, 0, 0,  1,  0, CMD_NONE,  0};
        vec[14] = '{0,1,0,0,1, 0, 0,  1,  0, CMD_NONE,  0};  // tick, right pressed
        vec[15] = '{0,1,0,0,0, 1, 1,  1,  1, CMD_GRAV,  0};  // blocked gravity
        vec[16] = '{0,1,0,0,0, 0, 0,  1,  0, CMD_NONE,  1};  // lock cycle
        vec[17] = '{0,1,0,0,0, 0, 0,  2,  0, CMD_NONE,  0};  // held right stays quiet
        vec[18] = '{0,0,0,0,0, 0, 0,  1,  0, CMD_NONE,  0};
        vec[19] = '{0,0,1,0,0, 0, 0,  1,  0, CMD_NONE,  0};  // down press
        vec[20] = '{0,0,0,0,0, 0, 0,  1,  1, CMD_DOWN,  0};
        vec[21] = '{0,1,0,0,0, 0, 0,  1,  1, CMD_DOWN,  0};  // right press while waiting
        vec[22] = '{0,0,0,0,0, 0, 0,  4,  1, CMD_DOWN,  0};
        vec[23] = '{0,0,0,0,0, 1, 0,  1,  1, CMD_DOWN,  0};
        vec[24] = '{0,0,0,0,0, 0, 0,  1,  0, CMD_NONE,  0};
        vec[25] = '{0,0,0,0,0, 1, 0,  1,  1, CMD_RIGHT, 0};
        vec[26] = '{0,0,0,0,0, 0, 0,  1,  0, CMD_NONE,  0};
        vec[27] = '{0,0,0,0,0, 1, 1,  2,  0, CMD_NONE,  0};  // ack while idle
        vec[28] = '{0,0,0,0,0, 0, 0,  1,  0, CMD_NONE,  0};

        drive(0,0,0,0,0,0,0);
        reset = 1'b0;
        #1;
        expect_out("reset", 1'b0, CMD_NONE, 1'b0);
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;

        // Directed table
        for (int i = 0; i < 29; i++) begin
            for (int r = 0; r < vec[i].reps; r++) begin
                drive(vec[i].l, vec[i].r, vec[i].d, vec[i].s, vec[i].g, vec[i].ack, vec[i].blk);
                tick_chk($sformatf("vec%0d", i), vec[i].ev, vec[i].ec, vec[i].el);
            end
        end

        // Reset during OFFER takes effect without a clock edge
        drive(1,0,0,0,0,0,0);
        tick_chk("rst_pre", 1'b0, CMD_NONE, 1'b0);
        drive(0,0,0,0,0,0,0);
        @(negedge clk);
        expect_out("rst_offer", 1'b1, CMD_LEFT, 1'b0);
        reset = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, CMD_NONE, 1'b0);
        @(posedge clk); #1; reset = 1'b1;
        for (int i = 0; i < 3; i++) tick_chk("rst_quiet", 1'b0, CMD_NONE, 1'b0);
        drive(0,0,0,1,0,1,0);
        tick_chk("rst_new", 1'b0, CMD_NONE, 1'b0);
        drive(0,0,0,0,0,1,0);
        tick_chk("rst_new", 1'b1, CMD_SPIN, 1'b0);
        tick_chk("rst_new", 1'b0, CMD_NONE, 1'b0);

        // A key held through reset release counts as one press
        drive(1,0,0,0,0,1,0);
        reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        tick_chk("held_rel", 1'b0, CMD_NONE, 1'b0);
        tick_chk("held_rel", 1'b1, CMD_LEFT, 1'b0);
        drive(0,0,0,0,0,0,0);
        tick_chk("held_rel", 1'b0, CMD_NONE, 1'b0);

        // Randomized run against the reference model
        reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) k_left  = ~k_left;
            if ($urandom_range(0, 5) == 0) k_right = ~k_right;
            if ($urandom_range(0, 7) == 0) k_down  = ~k_down;
            if ($urandom_range(0, 7) == 0) k_spin  = ~k_spin;
            drop            = ($urandom_range(0, 9) == 0);
            eng.moveAck     = ($urandom_range(0, 1) == 1);
            eng.moveBlocked = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            expect_out("rand", m_offer != 0, move_cmd_t'(m_offer), m_lock);
            if (i == 1700) begin
                reset = 1'b0;
                #1;
                expect_out("rand_rst", 1'b0, CMD_NONE, 1'b0);
                model_reset();
                @(posedge clk); #1; reset = 1'b1;
            end else begin
                model_step();
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
